// File: rtl/dff_response_checker_if.sv
// Observation bus between a D-FF under test and its response checker.
// master drives the observed nets and controls; slave is the checker side.
interface dff_response_checker_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             clear;
  logic             dut_d;
  logic             dut_rst_n;
  logic             dut_q;
  logic             mismatch;
  logic             fail;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] chk_count;
  logic [1:0]       state;

  modport master (
    output en, clear, dut_d, dut_rst_n, dut_q,
    input  mismatch, fail, err_count, chk_count, state
  );
  modport slave (
    input  en, clear, dut_d, dut_rst_n, dut_q,
    output mismatch, fail, err_count, chk_count, state
  );
endinterface

// File: rtl/dff_response_checker.sv
// Response checker for a D flip-flop: predicts q from the sampled d/reset history,
// compares against the observed q and keeps saturating check/error counters.
module dff_response_checker #(
  parameter int   LATENCY      = 1,
  parameter logic RESET_VAL    = 1'b0,
  parameter int   CNT_W        = 16,
  parameter bit   STOP_ON_FAIL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  dff_response_checker_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_CHECK = 2'd2, S_FAIL = 2'd3} state_e;

  state_e             st, st_nxt;
  logic [LATENCY-1:0] exp_pipe;
  logic [LATENCY-1:0] vld_pipe;
  logic               vld_last_nxt;
  logic               exp_q, cmp_en, err;
  logic               mm_q, fail_q;
  logic [CNT_W-1:0]   err_cnt, chk_cnt;

  // Value the top valid bit takes at this edge if the DUT stays out of reset.
  if (LATENCY == 1) begin : g_lat1
    assign vld_last_nxt = 1'b1;
  end else begin : g_latn
    assign vld_last_nxt = vld_pipe[LATENCY-2];
  end

  always_comb begin
    exp_q  = bus.dut_rst_n ? exp_pipe[LATENCY-1] : RESET_VAL;
    // Reset-held edges are checked even while the pipeline is refilling.
    cmp_en = ((st == S_CHECK) && vld_pipe[LATENCY-1]) ||
             (((st == S_FILL) || (st == S_CHECK)) && !bus.dut_rst_n);
    err    = cmp_en && (bus.dut_q != exp_q);
  end

  always_comb begin
    st_nxt = st;
    if (bus.clear) begin
      st_nxt = bus.en ? S_FILL : S_IDLE;
    end else begin
      case (st)
        S_IDLE:  if (bus.en) st_nxt = S_FILL;
        S_FILL, S_CHECK: begin
          if (err && STOP_ON_FAIL)                st_nxt = S_FAIL;
          else if (!bus.en)                       st_nxt = S_IDLE;
          else if (!bus.dut_rst_n)                st_nxt = S_FILL;
          else if (st == S_FILL && vld_last_nxt)  st_nxt = S_CHECK;
          else                                    st_nxt = st;
        end
        default: st_nxt = S_FAIL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nxt;
  end

  // Prediction pipeline; a DUT reset reloads it regardless of d.
  always_ff @(posedge clk) begin
    if (rst || !bus.dut_rst_n) begin
      exp_pipe <= {LATENCY{RESET_VAL}};
    end else begin
      exp_pipe[0] <= bus.dut_d;
      for (int i = 1; i < LATENCY; i++) exp_pipe[i] <= exp_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.dut_rst_n || bus.clear) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= 1'b1;
      for (int i = 1; i < LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Clear beats a same-edge error, so the error is simply dropped.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      mm_q    <= 1'b0;
      fail_q  <= 1'b0;
      err_cnt <= '0;
      chk_cnt <= '0;
    end else begin
      mm_q <= err;
      if (err) begin
        fail_q <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end
      if (cmp_en && chk_cnt != '1) chk_cnt <= chk_cnt + CNT_W'(1);
    end
  end

  assign bus.mismatch  = mm_q;
  assign bus.fail      = fail_q;
  assign bus.err_count = err_cnt;
  assign bus.chk_count = chk_cnt;
  assign bus.state     = st;

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker: a behavioural D-FF model feeds three checker
// instances (different latency/width/stop settings); mismatch of u_a is scoreboarded.
module tb_dff_response_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dff_response_checker_if #(.CNT_W(16)) ia ();
  dff_response_checker_if #(.CNT_W(4))  ib ();
  dff_response_checker_if #(.CNT_W(4))  ic ();

  dff_response_checker #(.LATENCY(1), .RESET_VAL(1'b0), .CNT_W(16), .STOP_ON_FAIL(1'b0))
    u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  dff_response_checker #(.LATENCY(1), .RESET_VAL(1'b0), .CNT_W(4), .STOP_ON_FAIL(1'b0))
    u_b (.clk(clk), .rst(rst), .bus(ib.slave));
  dff_response_checker #(.LATENCY(2), .RESET_VAL(1'b0), .CNT_W(4), .STOP_ON_FAIL(1'b1))
    u_c (.clk(clk), .rst(rst), .bus(ic.slave));

  logic d = 1'b0, rn = 1'b1, clr = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic inv_a = 1'b0, inv_b = 1'b0, inv_c = 1'b0;
  logic h0 = 1'b0, h1 = 1'b0;   // model flop output and one extra delay stage

  always @(posedge clk) begin
    if (!rn) begin h0 <= 1'b0; h1 <= 1'b0; end
    else     begin h0 <= d;    h1 <= h0;   end
  end

  assign ia.dut_d = d;  assign ia.dut_rst_n = rn; assign ia.clear = clr; assign ia.en = en_a;
  assign ib.dut_d = d;  assign ib.dut_rst_n = rn; assign ib.clear = clr; assign ib.en = en_b;
  assign ic.dut_d = d;  assign ic.dut_rst_n = rn; assign ic.clear = clr; assign ic.en = en_c;
  assign ia.dut_q = (rn & h0) ^ inv_a;
  assign ib.dut_q = (rn & h0) ^ inv_b;
  assign ic.dut_q = (rn & h1) ^ inv_c;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Push the expected u_a mismatch for this edge, clock it, then compare.
  task automatic tick(input logic exp_mm);
    logic e;
    sb_q.push_back(exp_mm);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("mismatch_a", {31'd0, ia.mismatch}, {31'd0, e});
  endtask

  initial begin
    // Reset with random DUT nets
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d = 1'($urandom); rn = 1'($urandom); inv_a = 1'($urandom); en_a = 1'($urandom);
      clr = 1'($urandom);
      tick(1'b0);
    end
    chk("rst_state_a", ia.state, 0);  chk("rst_err_a", ia.err_count, 0);
    chk("rst_chk_a", ia.chk_count, 0); chk("rst_fail_a", ia.fail, 0);
    chk("rst_state_c", ic.state, 0);  chk("rst_fail_b", ib.fail, 0);
    rst = 1'b0; rn = 1'b1; inv_a = 1'b0; en_a = 1'b0; clr = 1'b0; d = 1'b0;

    // Clean alternating stream on u_a
    en_a = 1'b1;
    tick(1'b0);
    chk("fill_state_a", ia.state, 1);
    for (int i = 0; i < 20; i++) begin d = 1'(i % 2); tick(1'b0); end
    chk("clean_err_a", ia.err_count, 0);
    chk("clean_chk_a", ia.chk_count, 19);
    chk("clean_state_a", ia.state, 2);

    // Single inverted q at the tenth edge
    for (int i = 1; i <= 20; i++) begin
      d = 1'(i % 2); inv_a = (i == 10); tick(i == 10);
    end
    inv_a = 1'b0;
    chk("inv_err_a", ia.err_count, 1);
    chk("inv_chk_a", ia.chk_count, 39);
    chk("inv_fail_a", ia.fail, 1);

    // DUT reset held two edges, q correct
    d = 1'b1; rn = 1'b0; tick(1'b0); tick(1'b0);
    chk("dutrst_chk_a", ia.chk_count, 41);
    chk("dutrst_state_a", ia.state, 1);
    rn = 1'b1; d = 1'b0; tick(1'b0);
    chk("release_state_a", ia.state, 2);
    chk("release_chk_a", ia.chk_count, 41);

    // DUT reset held two edges, q wrongly high
    d = 1'b1; rn = 1'b0; inv_a = 1'b1; tick(1'b1); tick(1'b1);
    inv_a = 1'b0; rn = 1'b1; d = 1'b0;
    chk("dutrst_err_a", ia.err_count, 3);
    tick(1'b0); tick(1'b0);
    chk("post_chk_a", ia.chk_count, 44);
    chk("post_fail_a", ia.fail, 1);

    // Error and clear on the same edge: clear wins
    inv_a = 1'b1; clr = 1'b1; tick(1'b0);
    inv_a = 1'b0; clr = 1'b0;
    chk("clr_err_a", ia.err_count, 0); chk("clr_chk_a", ia.chk_count, 0);
    chk("clr_fail_a", ia.fail, 0);     chk("clr_state_a", ia.state, 1);

    // Saturation on the 4-bit instance
    en_a = 1'b0; en_b = 1'b1; inv_b = 1'b1;
    for (int i = 0; i < 21; i++) begin d = 1'($urandom); tick(1'b0); end
    chk("sat_err_b", ib.err_count, 15); chk("sat_chk_b", ib.chk_count, 15);
    for (int i = 0; i < 3; i++) begin d = 1'($urandom); tick(1'b0); end
    chk("hold_err_b", ib.err_count, 15); chk("hold_chk_b", ib.chk_count, 15);
    chk("sat_fail_b", ib.fail, 1);
    en_b = 1'b0; inv_b = 1'b0;

    // Stop-on-fail with latency 2
    en_c = 1'b1;
    for (int i = 0; i < 7; i++) begin d = 1'($urandom); tick(1'b0); end
    chk("c_err0", ic.err_count, 0); chk("c_chk0", ic.chk_count, 5);
    chk("c_state0", ic.state, 2);
    inv_c = 1'b1; d = 1'($urandom); tick(1'b0);
    chk("c_fail_state", ic.state, 3);
    for (int i = 0; i < 3; i++) begin d = 1'($urandom); tick(1'b0); end
    chk("c_frozen_err", ic.err_count, 1); chk("c_frozen_chk", ic.chk_count, 6);
    chk("c_frozen_state", ic.state, 3); chk("c_fail", ic.fail, 1);
    inv_c = 1'b0; clr = 1'b1; tick(1'b0);
    clr = 1'b0;
    chk("c_clr_err", ic.err_count, 0); chk("c_clr_chk", ic.chk_count, 0);
    chk("c_clr_fail", ic.fail, 0);    chk("c_clr_state", ic.state, 1);
    d = 1'($urandom); tick(1'b0);
    chk("c_fill_state", ic.state, 1);
    d = 1'($urandom); tick(1'b0);
    chk("c_check_state", ic.state, 2);
    for (int i = 0; i < 3; i++) begin d = 1'($urandom); tick(1'b0); end
    chk("c_recheck_chk", ic.chk_count, 3); chk("c_recheck_err", ic.err_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
